sumador_pipe_nb: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor for the ALU datapath. It is the registered successor of the combinational ripple adder. The operand width is split into STAGES equal chunks, and each stage adds one chunk. Carries pass between stages through registers, so timing closes at wide N. Results carry ALU flags and a valid tag, and a stall input freezes the whole pipe.

---
 rtl/sumador_pipe_nb_if.sv | 34 +++
 rtl/sumador_pipe_nb.sv | 120 ++++++++++++
 tb/tb_sumador_pipe_nb.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sumador_pipe_nb_if.sv
// Operand/result bundle of the pipelined adder/subtractor.
// Latency: none (wires only); the adder adds STAGES cycles.
// Backpressure: stall travels with the operands and freezes the whole pipe.
//
// Port summary:
//   master : drives in_valid, stall, op_sub, a, b, ci; observes results
//   slave  : the adder; consumes operands, drives out_valid, sum, co, ovf, zero, neg
interface sumador_pipe_nb_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         stall;
    logic         op_sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;

    logic         out_valid;
    logic [N-1:0] sum;
    logic         co;
    logic         ovf;
    logic         zero;
    logic         neg;

    modport master (
        output in_valid, stall, op_sub, a, b, ci,
        input  out_valid, sum, co, ovf, zero, neg
    );

    modport slave (
        input  in_valid, stall, op_sub, a, b, ci,
        output out_valid, sum, co, ovf, zero, neg
    );
endinterface

// File: rtl/sumador_pipe_nb.sv
// Pipelined N-bit adder/subtractor; each stage adds one CHUNK-wide slice.
// Latency: exactly STAGES cycles from accepting edge to out_valid.
// Backpressure: stall=1 freezes every register; in_valid is dropped while stalled.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high clear of all registers (wins over stall)
//   bus  : slave side of sumador_pipe_nb_if (operands in, result + flags out)
module sumador_pipe_nb #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    sumador_pipe_nb_if.slave  bus
);
    localparam int CHUNK = N / STAGES;
    localparam int LAST  = STAGES - 1;

    // Subtraction is a + ~b + 1, so the +1 rides in as the stage-0 carry.
    logic [N-1:0] bb;
    logic         c0;
    assign bb = bus.op_sub ? ~bus.b : bus.b;
    assign c0 = bus.op_sub | bus.ci;

    // Each stage works on one word laid out as {b_remaining, a_remaining, sum_done}:
    //   [LO-1:0]      finished low sum chunks (deskew)
    //   [N-1:LO]      a bits not yet added (skew)
    //   [2N-LO-1:N]   b bits not yet added (skew)
    // Stage k replaces a-chunk k with its sum and drops b-chunk k, so the word
    // shrinks by CHUNK bits per stage and is exactly the N-bit result at the end.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * CHUNK;
        localparam int WI = 2 * N - LO;

        logic [WI-1:0]       w_in;
        logic [WI-CHUNK-1:0] w_nxt;
        logic                cin;
        logic                vin;
        logic [CHUNK:0]      csum;
        logic [N-1:0]        sum_n;

        if (k == 0) begin : g_src
            assign w_in = {bb, bus.a};
            assign cin  = c0;
            assign vin  = bus.in_valid;
        end else begin : g_src
            logic [WI-1:0] w_q;
            logic          c_q;
            logic          v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    w_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (!bus.stall) begin
                    w_q <= g_st[k-1].w_nxt;
                    c_q <= g_st[k-1].csum[CHUNK];
                    v_q <= g_st[k-1].vin;
                end
            end

            assign w_in = w_q;
            assign cin  = c_q;
            assign vin  = v_q;
        end

        assign csum = {1'b0, w_in[LO +: CHUNK]} + {1'b0, w_in[N +: CHUNK]}
                    + {{CHUNK{1'b0}}, cin};

        always_comb begin
            sum_n               = w_in[N-1:0];
            sum_n[LO +: CHUNK]  = csum[CHUNK-1:0];
        end

        if (k == STAGES - 1) begin : g_nxt
            assign w_nxt = sum_n;
        end else begin : g_nxt
            assign w_nxt = {w_in[WI-1:N+CHUNK], sum_n};
        end
    end

    // Carry into bit N-1 is recovered as a^b^s on the MSB of the last chunk.
    logic ovf_d;
    assign ovf_d = g_st[LAST].w_in[N-1] ^ g_st[LAST].w_in[N+CHUNK-1]
                 ^ g_st[LAST].csum[CHUNK-1] ^ g_st[LAST].csum[CHUNK];

    logic         out_valid_q;
    logic [N-1:0] sum_q;
    logic         co_q;
    logic         ovf_q;
    logic         zero_q;
    logic         neg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (!bus.stall) begin
            out_valid_q <= g_st[LAST].vin;
            sum_q       <= g_st[LAST].w_nxt;
            co_q        <= g_st[LAST].csum[CHUNK];
            ovf_q       <= ovf_d;
            zero_q      <= ~|g_st[LAST].w_nxt;
            neg_q       <= g_st[LAST].w_nxt[N-1];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
endmodule

// File: tb/tb_sumador_pipe_nb.sv
// Bench for sumador_pipe_nb: three configurations (8/2, 8/4, 32/4) share one
// operand stream; a delay-line reference model predicts every output cycle.
module tb_sumador_pipe_nb;
    logic        clk;
    logic        rst_d;
    logic        in_valid_d;
    logic        stall_d;
    logic        sub_d;
    logic        ci_d;
    logic [31:0] a_d;
    logic [31:0] b_d;

    int n_chk;
    int n_fail;

    sumador_pipe_nb_if #(.N(8))  if0 ();
    sumador_pipe_nb_if #(.N(8))  if1 ();
    sumador_pipe_nb_if #(.N(32)) if2 ();

    assign if0.in_valid = in_valid_d;
    assign if0.stall    = stall_d;
    assign if0.op_sub   = sub_d;
    assign if0.ci       = ci_d;
    assign if0.a        = a_d[7:0];
    assign if0.b        = b_d[7:0];

    assign if1.in_valid = in_valid_d;
    assign if1.stall    = stall_d;
    assign if1.op_sub   = sub_d;
    assign if1.ci       = ci_d;
    assign if1.a        = a_d[7:0];
    assign if1.b        = b_d[7:0];

    assign if2.in_valid = in_valid_d;
    assign if2.stall    = stall_d;
    assign if2.op_sub   = sub_d;
    assign if2.ci       = ci_d;
    assign if2.a        = a_d;
    assign if2.b        = b_d;

    sumador_pipe_nb #(.N(8),  .STAGES(2)) u_d0 (.clk(clk), .rst(rst_d), .bus(if0));
    sumador_pipe_nb #(.N(8),  .STAGES(4)) u_d1 (.clk(clk), .rst(rst_d), .bus(if1));
    sumador_pipe_nb #(.N(32), .STAGES(4)) u_d2 (.clk(clk), .rst(rst_d), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
    } op_t;

    // hist[L] is the operation that must be at the output of a STAGES=L pipe.
    op_t hist [0:4];
    bit  just_rst;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Plain-arithmetic result for width n: returns {ovf, co, sum}.
    function automatic logic [33:0] model(input op_t op, input int n);
        logic [63:0] mask, aa, bb, full;
        logic [31:0] s;
        logic        c, o;
        mask = (64'd1 << n) - 64'd1;
        aa   = {32'd0, op.a} & mask;
        bb   = (op.sub ? ~{32'd0, op.b} : {32'd0, op.b}) & mask;
        full = aa + bb + (op.sub ? 64'd1 : {63'd0, op.ci});
        s    = full[31:0] & mask[31:0];
        c    = full[n];
        o    = (aa[n-1] == bb[n-1]) && (s[n-1] != aa[n-1]);
        return {o, c, s};
    endfunction

    function automatic void check_inst(input string nm, input int n, input int lat,
                                       input logic ov, input logic [31:0] s,
                                       input logic c, input logic o,
                                       input logic z, input logic ng);
        logic [33:0] e;
        if (just_rst) begin
            chk({nm, "_rst_valid"}, {31'd0, ov}, 32'd0);
            chk({nm, "_rst_sum"}, s, 32'd0);
            chk({nm, "_rst_flags"}, {28'd0, c, o, z, ng}, 32'd0);
        end else begin
            chk({nm, "_valid"}, {31'd0, ov}, {31'd0, hist[lat].v});
            if (hist[lat].v) begin
                e = model(hist[lat], n);
                chk({nm, "_sum"},  s, e[31:0]);
                chk({nm, "_co"},   {31'd0, c},  {31'd0, e[32]});
                chk({nm, "_ovf"},  {31'd0, o},  {31'd0, e[33]});
                chk({nm, "_zero"}, {31'd0, z},  {31'd0, e[31:0] == 32'd0});
                chk({nm, "_neg"},  {31'd0, ng}, {31'd0, e[n-1]});
            end
        end
    endfunction

    // Reference model + per-cycle compare.
    initial begin
        op_t  cur;
        logic r, st;
        for (int i = 0; i <= 4; i++) hist[i] = '0;
        just_rst = 1'b0;
        forever begin
            @(posedge clk);
            cur = '{in_valid_d, a_d, b_d, ci_d, sub_d};
            r   = rst_d;
            st  = stall_d;
            #2;
            if (r) begin
                for (int i = 0; i <= 4; i++) hist[i] = '0;
                just_rst = 1'b1;
            end else begin
                just_rst = 1'b0;
                if (!st) begin
                    for (int i = 4; i >= 2; i--) hist[i] = hist[i-1];
                    hist[1] = cur;
                end
            end
            check_inst("d0", 8, 2, if0.out_valid, {24'd0, if0.sum}, if0.co, if0.ovf, if0.zero, if0.neg);
            check_inst("d1", 8, 4, if1.out_valid, {24'd0, if1.sum}, if1.co, if1.ovf, if1.zero, if1.neg);
            check_inst("d2", 32, 4, if2.out_valid, if2.sum, if2.co, if2.ovf, if2.zero, if2.neg);
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub);
        in_valid_d = v;
        a_d        = a;
        b_d        = b;
        ci_d       = ci;
        sub_d      = sub;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            stall_d = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] got [$];
        logic        snap_v0, snap_v2;
        logic [31:0] snap_s0, snap_s2;
        int          cnt;
        logic [31:0] pick [0:5];

        n_chk      = 0;
        n_fail     = 0;
        rst_d      = 1'b1;
        stall_d    = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_d = 1'b0;
        flush(2);

        // 8-bit, 2 stages: signed overflow into the sign bit.
        @(negedge clk); drive(1'b1, 32'h7F, 32'h01, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #3;
        chk("t1_valid", {31'd0, if0.out_valid}, 32'd1);
        chk("t1_sum", {24'd0, if0.sum}, 32'h80);
        chk("t1_flags_co_ovf_zero_neg", {28'd0, if0.co, if0.ovf, if0.zero, if0.neg}, 32'b0101);
        flush(3);

        // Carry crosses the chunk boundary through the stage register.
        @(negedge clk); drive(1'b1, 32'hFF, 32'h00, 1'b1, 1'b0);
        @(negedge clk); drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #3;
        chk("t2_valid", {31'd0, if0.out_valid}, 32'd1);
        chk("t2_sum", {24'd0, if0.sum}, 32'h00);
        chk("t2_flags_co_ovf_zero_neg", {28'd0, if0.co, if0.ovf, if0.zero, if0.neg}, 32'b1010);
        flush(3);

        // 8-bit, 4 stages: two back-to-back subtractions.
        @(negedge clk); drive(1'b1, 32'h05, 32'h07, 1'b0, 1'b1);
        @(negedge clk); drive(1'b1, 32'h80, 32'h01, 1'b1, 1'b1);
        @(negedge clk); drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #3;
        chk("t3a_sum", {24'd0, if1.sum}, 32'hFE);
        chk("t3a_flags_co_ovf_zero_neg", {28'd0, if1.co, if1.ovf, if1.zero, if1.neg}, 32'b0001);
        @(posedge clk); #3;
        chk("t3b_valid", {31'd0, if1.out_valid}, 32'd1);
        chk("t3b_sum", {24'd0, if1.sum}, 32'h7F);
        chk("t3b_flags_co_ovf_zero_neg", {28'd0, if1.co, if1.ovf, if1.zero, if1.neg}, 32'b1100);
        flush(5);

        // 32-bit, 4 stages: three streamed operations.
        @(negedge clk); drive(1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #3;
        chk("t4a_sum", if2.sum, 32'h00000000);
        chk("t4a_co", {31'd0, if2.co}, 32'd1);
        @(posedge clk); #3;
        chk("t4b_sum", if2.sum, 32'h23456789);
        @(posedge clk); #3;
        chk("t4c_sum", if2.sum, 32'hFFFFFFFF);
        chk("t4c_valid", {31'd0, if2.out_valid}, 32'd1);
        flush(5);

        // Stall mid-flight with a dropped in_valid pulse.
        cnt = 0;
        got.delete();
        snap_v0 = 1'b0; snap_v2 = 1'b0; snap_s0 = '0; snap_s2 = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            stall_d = (i >= 3 && i <= 7);
            if (i < 3)       drive(1'b1, i + 1, i + 1, 1'b0, 1'b0);
            else if (i == 5) drive(1'b1, 32'hDEAD0000, 32'h0000BEEF, 1'b0, 1'b0);
            else             drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            @(posedge clk); #3;
            if (i == 2) begin
                snap_v0 = if0.out_valid; snap_s0 = {24'd0, if0.sum};
                snap_v2 = if2.out_valid; snap_s2 = if2.sum;
            end
            if (stall_d) begin
                chk("stall_frz_d0_valid", {31'd0, if0.out_valid}, {31'd0, snap_v0});
                chk("stall_frz_d0_sum", {24'd0, if0.sum}, snap_s0);
                chk("stall_frz_d2_valid", {31'd0, if2.out_valid}, {31'd0, snap_v2});
                chk("stall_frz_d2_sum", if2.sum, snap_s2);
            end else if (if2.out_valid) begin
                cnt++;
                got.push_back(if2.sum);
            end
        end
        chk("stall_result_count", cnt, 32'd3);
        if (got.size() == 3) begin
            chk("stall_res0", got[0], 32'd2);
            chk("stall_res1", got[1], 32'd4);
            chk("stall_res2", got[2], 32'd6);
        end
        flush(2);

        // Reset while two operations are in flight.
        @(negedge clk); drive(1'b1, 32'h10, 32'h20, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 32'h30, 32'h40, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0); rst_d = 1'b1;
        @(posedge clk); #3;
        chk("rst_d2_valid", {31'd0, if2.out_valid}, 32'd0);
        chk("rst_d2_sum", if2.sum, 32'd0);
        chk("rst_d2_flags", {28'd0, if2.co, if2.ovf, if2.zero, if2.neg}, 32'd0);
        @(negedge clk); rst_d = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #3;
            cnt += int'(if0.out_valid) + int'(if1.out_valid) + int'(if2.out_valid);
        end
        chk("rst_no_stale", cnt, 32'd0);

        // Randomised traffic with stalls, bubbles and occasional resets.
        pick[0] = 32'h00000000; pick[1] = 32'hFFFFFFFF; pick[2] = 32'h80000000;
        pick[3] = 32'h7FFFFFFF; pick[4] = 32'h0000007F; pick[5] = 32'h00000080;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst_d   = ($urandom_range(0, 99) == 0);
            stall_d = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom,
                  ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk); rst_d = 1'b0;
        flush(6);
        @(posedge clk); #4;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
